// File: rtl/debounce_sync_if.sv
// debounce_sync_if: raw level in, conditioned level and diagnostics out
//   data_in      raw asynchronous level from a pin or switch
//   data         debounced level, synchronous to clk
//   rise_pulse   one cycle high on a 0->1 change of data
//   fall_pulse   one cycle high on a 1->0 change of data
//   busy         a candidate change is being qualified
//   glitch_count aborted candidates, saturating at 255
//   master: the conditioning stage; slave: the consumer of the clean level
interface debounce_sync_if;
  logic       data_in;
  logic       data;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       busy;
  logic [7:0] glitch_count;
  modport master (input data_in, output data, rise_pulse, fall_pulse, busy, glitch_count);
  modport slave  (output data_in, input data, rise_pulse, fall_pulse, busy, glitch_count);
endinterface

// File: rtl/debounce_sync.sv
// debounce_sync: synchronise and debounce a raw level, with edge pulses and glitch count
//   clk   rising-edge clock
//   reset asynchronous active-high reset
//   bus   debounce_sync_if.master (data_in in; data, pulses, busy, glitch_count out)
module debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter int   CNT_W           = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input logic clk,
  input logic reset,
  debounce_sync_if.master bus
);
  typedef enum logic {STABLE, WAIT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   data_q, data_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [7:0]             glitch_q, glitch_d;
  logic                   sync_q;
  logic                   differ;
  assign chain_d = {chain_q[SYNC_STAGES-2:0], bus.data_in};
  assign sync_q  = chain_q[SYNC_STAGES-1];
  assign differ  = sync_q != data_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STABLE;
      chain_q  <= {SYNC_STAGES{RESET_VAL}};
      cnt_q    <= '0;
      data_q   <= RESET_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      chain_q  <= chain_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end
  // any matching sample while waiting aborts; a partial count is never resumed
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    data_d   = data_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    if (state_q == STABLE) begin
      state_d = differ ? WAIT : STABLE;
      cnt_d   = differ ? CNT_W'(1) : '0;
    end else if (!differ) begin
      state_d  = STABLE;
      glitch_d = glitch_q + {7'd0, glitch_q != 8'hFF};
    end else if (cnt_q == LAST) begin
      state_d = STABLE;
      data_d  = ~data_q;
      rise_d  = ~data_q;
      fall_d  = data_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_comb begin
    bus.busy         = state_q == WAIT;
    bus.data         = data_q;
    bus.rise_pulse   = rise_q;
    bus.fall_pulse   = fall_q;
    bus.glitch_count = glitch_q;
  end
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed vector table plus hand sequences for debounce_sync
module tb_debounce_sync;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;
  always #5 clk = ~clk;
  debounce_sync_if u_if ();
  debounce_sync_if f_if ();
  debounce_sync u_dut (.clk(clk), .reset(reset), .bus(u_if.master));
  debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) f_dut (.clk(clk), .reset(reset), .bus(f_if.master));
  typedef struct packed {
    logic       din;
    logic       data;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] gc;
  } vec_t;
  vec_t vecs [26];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] outs();
    return {4'd0, u_if.data, u_if.rise_pulse, u_if.fall_pulse, u_if.busy, u_if.glitch_count};
  endfunction
  function automatic logic [15:0] exp_of(input vec_t v);
    return {4'd0, v.data, v.rise, v.fall, v.busy, v.gc};
  endfunction
  initial begin
    logic bad;
    vecs = '{
      // bounce from data=0: high 2, low 1, then held high
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
      // clean fall
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
      // clean rise
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
      '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1}
    };
    u_if.data_in = 1'b0;
    f_if.data_in = 1'b0;
    tick();
    tick();
    chk("reset_outputs", outs(), 16'h0000);
    chk("reset_fast_data", {15'd0, f_if.data}, 16'd0);
    reset = 1'b0;
    // reset in the middle of qualification
    u_if.data_in = 1'b1;
    tick();
    tick();
    tick();
    chk("midwait_busy", {15'd0, u_if.busy}, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midwait_reset_outputs", outs(), 16'h0000);
    u_if.data_in = 1'b0;
    tick();
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      bad |= u_if.rise_pulse | u_if.fall_pulse | u_if.data | u_if.busy;
    end
    chk("no_pulse_after_reset", {15'd0, bad}, 16'd0);
    for (int i = 0; i < 26; i++) begin
      u_if.data_in = vecs[i].din;
      tick();
      chk($sformatf("vec%0d", i), outs(), exp_of(vecs[i]));
    end
    // saturation: data=1, repeated two-sample low glitches
    bad = 1'b0;
    for (int g = 0; g < 310; g++) begin
      for (int k = 0; k < 4; k++) begin
        u_if.data_in = k >= 2;
        tick();
        bad |= u_if.rise_pulse | u_if.fall_pulse | ~u_if.data;
      end
      if (g == 99) begin
        tick();
        tick();
        chk("glitch_count_101", {8'd0, u_if.glitch_count}, 16'd101);
      end
      if (g == 299) begin
        tick();
        tick();
        chk("glitch_count_sat", {8'd0, u_if.glitch_count}, 16'd255);
      end
    end
    tick();
    tick();
    chk("glitch_count_hold", {8'd0, u_if.glitch_count}, 16'd255);
    chk("glitch_data_stable", {15'd0, bad}, 16'd0);
    // short configuration: 3 sync stages, 2 debounce cycles
    f_if.data_in = 1'b1;
    tick();
    tick();
    tick();
    chk("fast_e3", {14'd0, f_if.data, f_if.busy}, 16'b00);
    tick();
    chk("fast_e4", {13'd0, f_if.data, f_if.rise_pulse, f_if.busy}, 16'b001);
    tick();
    chk("fast_e5", {13'd0, f_if.data, f_if.rise_pulse, f_if.busy}, 16'b110);
    tick();
    chk("fast_e6_rise_drop", {14'd0, f_if.data, f_if.rise_pulse}, 16'b10);
    f_if.data_in = 1'b0;
    tick();
    f_if.data_in = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      bad |= f_if.rise_pulse | f_if.fall_pulse | ~f_if.data;
    end
    chk("fast_glitch_no_pulse", {15'd0, bad}, 16'd0);
    chk("fast_glitch_count", {8'd0, f_if.glitch_count}, 16'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
